// File: rtl/tl_check_pkg.sv
// rtl/tl_check_pkg.sv - TileLink opcode, error code and beat-count helpers
package tl_check_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGIC       = 3'd3,
    A_GET         = 3'd4,
    A_HINT        = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_opcode_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_A_BUSY   = 3'd1,
    ERR_D_NOREQ  = 3'd2,
    ERR_D_OPCODE = 3'd3,
    ERR_D_SIZE   = 3'd4,
    ERR_WATCHDOG = 3'd5,
    ERR_A_FIELD  = 3'd6
  } err_code_e;

  // D opcode a well-behaved slave must answer a given A opcode with
  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_opcode);
    case (a_opcode)
      A_PUT_FULL, A_PUT_PARTIAL: return D_ACCESS_ACK;
      A_ARITH, A_LOGIC, A_GET:   return D_ACCESS_ACK_DATA;
      A_HINT:                    return D_HINT_ACK;
      default:                   return D_ACCESS_ACK;
    endcase
  endfunction

  // Beats in a burst: only data-carrying messages larger than the bus span several beats
  function automatic int unsigned num_beats(input logic [2:0] opcode, input int unsigned size,
                                            input logic is_d, input int unsigned beat_lg);
    logic has_data;
    has_data = is_d ? (opcode == D_ACCESS_ACK_DATA) : (opcode <= A_LOGIC);
    if (has_data && (size > beat_lg)) return 32'd1 << (size - beat_lg);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// rtl/tl_beat_counter.sv - per-channel beat counter producing first/last flags
module tl_beat_counter
  import tl_check_pkg::*;
#(
  parameter int SIZE_BITS     = 3,
  parameter int BEAT_BYTES_LG = 3,
  parameter bit IS_D          = 1'b0,
  parameter int CNT_BITS      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fire,
  input  logic [2:0]           opcode,
  input  logic [SIZE_BITS-1:0] size,
  output logic                 first,
  output logic                 last,
  output logic [CNT_BITS-1:0]  count
);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] limit_q, limit_d;
  logic [CNT_BITS-1:0] limit_now;

  // The burst length is fixed at the first beat so a corrupted size mid-burst cannot derail framing
  always_comb begin
    limit_now = CNT_BITS'(num_beats(opcode, 32'(size), IS_D, BEAT_BYTES_LG) - 32'd1);
    first     = (count_q == '0);
    last      = first ? (limit_now == '0) : (count_q == limit_q);
    count_d   = count_q;
    limit_d   = limit_q;
    if (fire) begin
      if (first) limit_d = limit_now;
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  assign count = count_q;

  // Counter and latched limit state
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/tl_inflight_tracker.sv
// rtl/tl_inflight_tracker.sv - passive TileLink A/D request tracker and protocol checker
module tl_inflight_tracker
  import tl_check_pkg::*;
#(
  parameter int SOURCE_BITS   = 4,
  parameter int SIZE_BITS     = 3,
  parameter int BEAT_BYTES_LG = 3,
  parameter int TIMEOUT       = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_valid,
  output logic [2:0]             err_code,
  output logic                   err_seen,
  output logic [SOURCE_BITS:0]   inflight_count,
  output logic                   busy
);

  localparam int NUM_SRC  = 1 << SOURCE_BITS;
  localparam int MAX_SIZE = (1 << SIZE_BITS) - 1;
  localparam int CNT_BITS = (MAX_SIZE > BEAT_BYTES_LG) ? (MAX_SIZE - BEAT_BYTES_LG) : 1;
  localparam int WD_BITS  = $clog2(TIMEOUT + 1);
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT);

  logic a_fire, d_fire;
  logic a_first, a_last, d_first, d_last;
  logic [CNT_BITS-1:0] a_beat_unused, d_beat_unused;

  logic [2:0]             a_op_q, a_op_d;
  logic [SIZE_BITS-1:0]   a_size_q, a_size_d;
  logic [SOURCE_BITS-1:0] a_src_q, a_src_d;

  logic [NUM_SRC-1:0]                inflight_q, inflight_d;
  logic [NUM_SRC-1:0][2:0]           exp_op_q, exp_op_d;
  logic [NUM_SRC-1:0][SIZE_BITS-1:0] exp_size_q, exp_size_d;

  logic                 d_noreq_q, d_noreq_d;
  logic [SOURCE_BITS:0] count_q, count_d;
  logic [WD_BITS-1:0]   wd_q, wd_d, wd_next;
  logic                 err_valid_q, err_valid_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 err_seen_q, err_seen_d;

  logic a_set, d_hit, d_clear, noreq_burst;
  logic e_a_busy, e_d_noreq, e_d_opcode, e_d_size, e_watchdog, e_a_field, any_err;

  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  tl_beat_counter #(
    .SIZE_BITS(SIZE_BITS), .BEAT_BYTES_LG(BEAT_BYTES_LG), .IS_D(1'b0), .CNT_BITS(CNT_BITS)
  ) u_a_beats (
    .clock(clock), .reset(reset), .fire(a_fire), .opcode(a_opcode), .size(a_size),
    .first(a_first), .last(a_last), .count(a_beat_unused)
  );

  tl_beat_counter #(
    .SIZE_BITS(SIZE_BITS), .BEAT_BYTES_LG(BEAT_BYTES_LG), .IS_D(1'b1), .CNT_BITS(CNT_BITS)
  ) u_d_beats (
    .clock(clock), .reset(reset), .fire(d_fire), .opcode(d_opcode), .size(d_size),
    .first(d_first), .last(d_last), .count(d_beat_unused)
  );

  // Protocol checks against pre-cycle state, table/counter updates and error selection
  always_comb begin
    a_op_d     = a_op_q;
    a_size_d   = a_size_q;
    a_src_d    = a_src_q;
    inflight_d = inflight_q;
    exp_op_d   = exp_op_q;
    exp_size_d = exp_size_q;
    d_noreq_d  = d_noreq_q;
    count_d    = count_q;
    wd_d       = wd_q;
    wd_next    = wd_q + 1'b1;

    a_set     = a_fire & a_first;
    e_a_busy  = a_set & inflight_q[a_source];
    e_a_field = a_fire & ~a_first &
                ((a_opcode != a_op_q) | (a_size != a_size_q) | (a_source != a_src_q));

    d_hit      = inflight_q[d_source];
    e_d_noreq  = d_fire & d_first & ~d_hit;
    e_d_opcode = d_fire & d_hit & (d_opcode != exp_op_q[d_source]);
    e_d_size   = d_fire & d_hit & (d_size != exp_size_q[d_source]);

    // A burst that started without a matching request must not retire someone else's entry
    noreq_burst = d_first ? ~d_hit : d_noreq_q;
    d_clear     = d_fire & d_last & ~noreq_burst;
    if (d_fire) d_noreq_d = d_last ? 1'b0 : noreq_burst;

    // Watchdog saturates so it pulses only once per stall
    e_watchdog = 1'b0;
    if (d_fire || (count_q == '0)) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d       = wd_next;
      e_watchdog = (wd_next == WD_LIMIT);
    end

    // Clear before set so a same-cycle reissue of the retiring source stays outstanding
    if (d_clear) inflight_d[d_source] = 1'b0;
    if (a_set) begin
      inflight_d[a_source] = 1'b1;
      exp_op_d[a_source]   = exp_d_opcode(a_opcode);
      exp_size_d[a_source] = a_size;
      a_op_d               = a_opcode;
      a_size_d             = a_size;
      a_src_d              = a_source;
    end

    if (a_set && !d_clear)      count_d = count_q + 1'b1;
    else if (!a_set && d_clear) count_d = count_q - 1'b1;

    any_err     = e_a_busy | e_d_noreq | e_d_opcode | e_d_size | e_watchdog | e_a_field;
    err_valid_d = any_err;
    err_seen_d  = err_seen_q | any_err;
    if (e_a_busy)        err_code_d = ERR_A_BUSY;
    else if (e_d_noreq)  err_code_d = ERR_D_NOREQ;
    else if (e_d_opcode) err_code_d = ERR_D_OPCODE;
    else if (e_d_size)   err_code_d = ERR_D_SIZE;
    else if (e_watchdog) err_code_d = ERR_WATCHDOG;
    else if (e_a_field)  err_code_d = ERR_A_FIELD;
    else                 err_code_d = ERR_NONE;
  end

  // All tracker state; reset discards anything still in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      a_op_q      <= '0;
      a_size_q    <= '0;
      a_src_q     <= '0;
      inflight_q  <= '0;
      exp_op_q    <= '0;
      exp_size_q  <= '0;
      d_noreq_q   <= 1'b0;
      count_q     <= '0;
      wd_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      a_op_q      <= a_op_d;
      a_size_q    <= a_size_d;
      a_src_q     <= a_src_d;
      inflight_q  <= inflight_d;
      exp_op_q    <= exp_op_d;
      exp_size_q  <= exp_size_d;
      d_noreq_q   <= d_noreq_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_seen_q  <= err_seen_d;
    end
  end

  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign err_seen       = err_seen_q;
  assign inflight_count = count_q;
  assign busy           = (count_q != '0);

endmodule

// File: doc/tl_inflight_tracker.md
# tl_inflight_tracker

Sequential TileLink-UL/UH protocol checker that observes the A and D channels on the same tap that feeds the TL monitor assertion wrapper, and tracks outstanding requests per source ID. It matches each D response to its A request, counts beats, and reports protocol violations as registered error pulses. The block is passive: it never drives ready or valid, and it sits alongside the monitor in the testbench and debug fabric.

## Interface
- SOURCE_BITS, 4: width of the source ID; tracks 2^SOURCE_BITS IDs.
- SIZE_BITS, 3: width of lg2 transfer size.
- BEAT_BYTES_LG, 3: lg2 of the data bus width in bytes (8-byte bus).
- TIMEOUT, 1024: watchdog limit in cycles; must be at least 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- a_valid, a_ready  in  1  A-channel handshake.
- a_opcode  in  3  A opcode.
- a_size  in  SIZE_BITS  A lg2 size.
- a_source  in  SOURCE_BITS  A source ID.
- d_valid, d_ready  in  1  D-channel handshake.
- d_opcode  in  3  D opcode.
- d_size  in  SIZE_BITS  D lg2 size.
- d_source  in  SOURCE_BITS  D source ID.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error code; valid only while err_valid is high.
- err_seen  out  1  sticky OR of all errors since reset.
- inflight_count  out  SOURCE_BITS+1  number of outstanding requests.
- busy  out  1  high when inflight_count is nonzero.

## Operation
- Fires: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
- Data-carrying A opcodes are 0–3 (Put, Arith, Logic). AccessAckData (1) is the only data-carrying D opcode.
- Beats: a burst is 2^(size−BEAT_BYTES_LG) beats when data-carrying and size > BEAT_BYTES_LG; otherwise it is 1 beat.
- Two beat counters, one for A and one for D. Each counter is 0 at the first beat and wraps to 0 after the last beat.
- A-burst field latch: opcode, size and source are captured on the A first beat and compared on every later beat of the burst.
- Per-source table: one inflight bit, expected D opcode and size.
  - Expected D opcode: Put (0 or 1) expects AccessAck (0). Arith, Logic and Get (2, 3, 4) expect AccessAckData (1). Hint (5) expects HintAck (2).
- A first-beat fire sets the entry. A D last-beat fire clears the entry, but only when the D burst raised no D_NO_REQUEST error.
- inflight_count: +1 on an A first beat, −1 on a D clear, unchanged when both occur in the same cycle.
- Error codes, all checked against the state before the current cycle:
  - 1 A_BUSY: A first beat whose source is already inflight. This includes the case where the same source clears on D in the same cycle.
  - 2 D_NOREQ: D first beat whose source is not inflight.
  - 3 D_OPCODE: D opcode differs from the expected opcode.
  - 4 D_SIZE: d_size differs from the recorded size.
  - 5 WATCHDOG: busy held for TIMEOUT consecutive cycles with no d_fire.
  - 6 A_FIELD: an A field changed mid-burst.
- Simultaneous errors in one cycle: err_code reports the lowest code. All errors set err_seen.
- Watchdog counter:
  - Clears on d_fire or when not busy; saturates at TIMEOUT.
  - Pulses once on reaching TIMEOUT, then re-arms only after it clears.
- Reset mid-burst: all tables, counters, latches, err_seen and the watchdog clear. Traffic still in flight is discarded, so its later D beats raise D_NOREQ.

## Timing
- err_valid and err_code are registered: they appear 1 cycle after the offending fire edge.
- inflight_count and busy update in the cycle after the fire.
- Reset values of every output: err_valid=0, err_code=0, err_seen=0, inflight_count=0, busy=0.
- Non-fire cycles (valid without ready) have no effect on any state.
- Fully pipelined: an A fire and a D fire are accepted in every cycle with no bubbles.

## Structure
- Package tl_check_pkg holds:
  - A and D opcode enums;
  - the err_code enum;
  - function exp_d_opcode(a_opcode);
  - function num_beats(opcode, size, is_d).
- Sub-module tl_beat_counter takes fire, opcode and size and produces first, last and count. It is instantiated twice, once for A and once for D.
- The per-source table is a flop array indexed by source. No RAM.

## Test plan
- Get (4), size 3, source 5 → AccessAckData, size 3, source 5: no error. inflight_count goes 0→1→0.
- PutFull, size 5 (4 beats), source 2, then AccessAck, source 2: no error. Changing a_size on beat 3 gives err_code 6 one cycle later.
- A first beats on source 7 twice with no D in between: err_code 1. Then an AccessAck on source 3 with nothing outstanding: err_code 2, and the table is unchanged.
- Get on source 1 answered by AccessAck (0): err_code 3. Get of size 2 answered with size 3: err_code 4. In the same D beat with both faults, err_code is 3.
- A Get to source 0 is outstanding with no D for 1024 cycles: exactly one err_code 5 pulse. A d_fire then re-arms the watchdog.
- All 16 sources issued, then responded in reverse order, with an A and a D fire in the same cycle: inflight_count peaks at 16 and ends at 0. Asserting reset mid-burst clears every output on the next cycle.
